// File: rtl/output_display.sv
// output_display: captures a bus byte on load, converts it to BCD with a sequential
// double-dabble and shows it on a 4-digit multiplexed 7-segment display.
// Optional two's-complement display is enabled by defining OUTPUT_SIGNED_EN.
module output_display #(
  parameter int REFRESH_DIV   = 1024,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] bus,
`ifdef OUTPUT_SIGNED_EN
  input  logic       signed_mode,
`endif
  output logic [7:0] value,
  output logic       busy,
  output logic [6:0] seg,
  output logic [3:0] digit_sel
);

  localparam int CW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [19:0]     shift_r, shift_s, adj_s;
  logic [2:0]      iter_r, iter_s;
  logic            sign_pend_r, sign_pend_s;
  logic            commit_s;
  logic            neg_s;
  logic [7:0]      mag_s;
  logic [7:0]      value_r;
  logic [3:0]      hund_r, tens_r, ones_r;
  logic            sign_r;
  logic [CW-1:0]   refresh_r;
  logic [3:0]      digit_sel_r;

  function automatic logic [3:0] dabble(input logic [3:0] n);
    if (n >= 4'd5) return n + 4'd3;
    else           return n;
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

`ifdef OUTPUT_SIGNED_EN
  assign neg_s = signed_mode & bus[7];
`else
  assign neg_s = 1'b0;
`endif
  // 0x80 negates to itself, which reads correctly as 128 unsigned
  assign mag_s = neg_s ? (~bus + 8'd1) : bus;

  assign adj_s = {dabble(shift_r[19:16]), dabble(shift_r[15:12]),
                  dabble(shift_r[11:8]), shift_r[7:0]};

  // Next-state logic; a load restarts the conversion from any state
  always_comb begin
    state_s     = state_r;
    shift_s     = shift_r;
    iter_s      = iter_r;
    sign_pend_s = sign_pend_r;
    commit_s    = 1'b0;
    if (load) begin
      state_s     = SHIFT;
      shift_s     = {12'd0, mag_s};
      iter_s      = 3'd0;
      sign_pend_s = neg_s;
    end else begin
      case (state_r)
        IDLE: state_s = IDLE;
        SHIFT: begin
          shift_s = adj_s << 1;
          iter_s  = iter_r + 3'd1;
          if (iter_r == 3'd7) state_s = COMMIT;
          else                state_s = SHIFT;
        end
        COMMIT: begin
          commit_s = 1'b1;
          state_s  = IDLE;
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // Conversion state, captured byte and committed display registers
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_r     <= IDLE;
      shift_r     <= 20'd0;
      iter_r      <= 3'd0;
      sign_pend_r <= 1'b0;
      value_r     <= 8'd0;
      hund_r      <= 4'd0;
      tens_r      <= 4'd0;
      ones_r      <= 4'd0;
      sign_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      shift_r     <= shift_s;
      iter_r      <= iter_s;
      sign_pend_r <= sign_pend_s;
      if (load) value_r <= bus;
      if (commit_s) begin
        hund_r <= shift_r[19:16];
        tens_r <= shift_r[15:12];
        ones_r <= shift_r[11:8];
        sign_r <= sign_pend_r;
      end
    end
  end

  // Digit multiplex timer, free-running regardless of conversion state
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      refresh_r   <= '0;
      digit_sel_r <= 4'b0001;
    end else if (refresh_r == CW'(REFRESH_DIV - 1)) begin
      refresh_r   <= '0;
      digit_sel_r <= {digit_sel_r[2:0], digit_sel_r[3]};
    end else begin
      refresh_r   <= refresh_r + CW'(1);
    end
  end

  // Segment pattern for the currently selected digit
  always_comb begin
    seg = 7'h00;
    case (digit_sel_r)
      4'b0001: seg = seg_code(ones_r);
      4'b0010: begin
        if (BLANK_LEADING && hund_r == 4'd0 && tens_r == 4'd0) seg = 7'h00;
        else                                                  seg = seg_code(tens_r);
      end
      4'b0100: begin
        if (BLANK_LEADING && hund_r == 4'd0) seg = 7'h00;
        else                                 seg = seg_code(hund_r);
      end
      4'b1000: begin
        if (sign_r) seg = 7'h40;
        else        seg = 7'h00;
      end
      default: seg = 7'h00;
    endcase
  end

  assign value     = value_r;
  assign busy      = (state_r != IDLE);
  assign digit_sel = digit_sel_r;

endmodule

// File: tb/tb_output_display.sv
// Scoreboard bench for output_display: stimulus pushes expected displays,
// a monitor pops and checks them each time a conversion finishes.
module tb_output_display;

  typedef struct {
    logic [7:0]  val;
    logic [27:0] s1;   // {d3,d2,d1,d0} with leading blanking
    logic [27:0] s0;   // {d3,d2,d1,d0} without leading blanking
  } exp_t;

  logic       clk = 1'b0;
  logic       clear, load, signed_mode, abort_flag;
  logic [7:0] bus;
  logic [7:0] value, value0;
  logic       busy, busy0;
  logic [6:0] seg, seg0;
  logic [3:0] digit_sel, digit_sel0;

  exp_t exp_q[$];
  int   n_cmp = 0, n_fail = 0, n_pushed = 0, n_commits = 0;

  always #5 clk = ~clk;

  output_display #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut (
    .clk(clk), .clear(clear), .load(load), .bus(bus),
`ifdef OUTPUT_SIGNED_EN
    .signed_mode(signed_mode),
`endif
    .value(value), .busy(busy), .seg(seg), .digit_sel(digit_sel));

  output_display #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) dut0 (
    .clk(clk), .clear(clear), .load(load), .bus(bus),
`ifdef OUTPUT_SIGNED_EN
    .signed_mode(signed_mode),
`endif
    .value(value0), .busy(busy0), .seg(seg0), .digit_sel(digit_sel0));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Samples 16 cycles so every digit position is seen at least once.
  task automatic collect_segs(output logic [27:0] a, output logic [27:0] b);
    a = 28'hFFFFFFF;
    b = 28'hFFFFFFF;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      case (digit_sel)
        4'b0001: begin a[6:0]   = seg; b[6:0]   = seg0; end
        4'b0010: begin a[13:7]  = seg; b[13:7]  = seg0; end
        4'b0100: begin a[20:14] = seg; b[20:14] = seg0; end
        4'b1000: begin a[27:21] = seg; b[27:21] = seg0; end
        default: ;
      endcase
    end
  endtask

  task automatic do_load(input logic [7:0] b, input logic sm, input logic push,
                         input logic [27:0] s1, input logic [27:0] s0);
    exp_t e;
    @(negedge clk);
    bus = b;
    signed_mode = sm;
    load = 1'b1;
    if (push) begin
      e.val = b; e.s1 = s1; e.s0 = s0;
      exp_q.push_back(e);
      n_pushed++;
    end
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  // Monitor: a busy falling edge means a commit just happened
  initial begin
    logic prev_busy;
    exp_t e;
    logic [27:0] a, b;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_busy && !busy && !abort_flag) begin
        n_commits++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_commit: value %0h committed with nothing expected", value);
        end else begin
          e = exp_q.pop_front();
          chk("value", value, e.val);
          chk("value_noblank", value0, e.val);
          collect_segs(a, b);
          chk("digits_blank", a, e.s1);
          chk("digits_noblank", b, e.s0);
        end
      end
      prev_busy = busy;
    end
  end

  initial begin
    logic [27:0] a, b;
    int nb;
    clear = 1'b1; load = 1'b0; bus = 8'h00; signed_mode = 1'b0; abort_flag = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_value", value, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_digit_sel", digit_sel, 4'b0001);
    chk("rst_seg", seg, 7'h3F);

    // Release reset and follow the digit rotation with REFRESH_DIV=4
    clear = 1'b0;
    a = 28'hFFFFFFF;
    b = 28'hFFFFFFF;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk("mux_order", digit_sel, 4'b0001 << ((k / 4) % 4));
      case (digit_sel)
        4'b0001: begin a[6:0]   = seg; b[6:0]   = seg0; end
        4'b0010: begin a[13:7]  = seg; b[13:7]  = seg0; end
        4'b0100: begin a[20:14] = seg; b[20:14] = seg0; end
        4'b1000: begin a[27:21] = seg; b[27:21] = seg0; end
        default: ;
      endcase
    end
    chk("rst_digits_blank", a, {7'h00, 7'h00, 7'h00, 7'h3F});
    chk("rst_digits_noblank", b, {7'h00, 7'h3F, 7'h3F, 7'h3F});

    // 255, with busy-length check
    do_load(8'hFF, 1'b0, 1'b1, {7'h00, 7'h5B, 7'h6D, 7'h6D}, {7'h00, 7'h5B, 7'h6D, 7'h6D});
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) nb++;
      else break;
    end
    chk("busy_cycles", nb, 9);
    repeat (24) @(negedge clk);

    do_load(8'h07, 1'b0, 1'b1, {7'h00, 7'h00, 7'h00, 7'h07}, {7'h00, 7'h3F, 7'h3F, 7'h07});
    repeat (30) @(negedge clk);
    do_load(8'h0A, 1'b0, 1'b1, {7'h00, 7'h00, 7'h06, 7'h3F}, {7'h00, 7'h3F, 7'h06, 7'h3F});
    repeat (30) @(negedge clk);

    // 42 aborted three cycles in by 100; only 100 may be committed
    do_load(8'h2A, 1'b0, 1'b0, 28'h0, 28'h0);
    repeat (2) @(negedge clk);
    do_load(8'h64, 1'b0, 1'b1, {7'h00, 7'h06, 7'h3F, 7'h3F}, {7'h00, 7'h06, 7'h3F, 7'h3F});
    repeat (30) @(negedge clk);

    do_load(8'h80, 1'b0, 1'b1, {7'h00, 7'h06, 7'h5B, 7'h7F}, {7'h00, 7'h06, 7'h5B, 7'h7F});
    repeat (30) @(negedge clk);

`ifdef OUTPUT_SIGNED_EN
    do_load(8'h80, 1'b1, 1'b1, {7'h40, 7'h06, 7'h5B, 7'h7F}, {7'h40, 7'h06, 7'h5B, 7'h7F});
    repeat (30) @(negedge clk);
    do_load(8'hFF, 1'b1, 1'b1, {7'h40, 7'h00, 7'h00, 7'h06}, {7'h40, 7'h3F, 7'h3F, 7'h06});
    repeat (30) @(negedge clk);
    signed_mode = 1'b0;
`endif

    // Asynchronous clear in the middle of a conversion
    do_load(8'h55, 1'b0, 1'b0, 28'h0, 28'h0);
    repeat (3) @(negedge clk);
    abort_flag = 1'b1;
    #2 clear = 1'b1;
    #1;
    chk("clr_busy", busy, 1'b0);
    chk("clr_value", value, 8'h00);
    chk("clr_digit_sel", digit_sel, 4'b0001);
    chk("clr_seg", seg, 7'h3F);
    @(negedge clk);
    clear = 1'b0;
    collect_segs(a, b);
    chk("clr_digits_blank", a, {7'h00, 7'h00, 7'h00, 7'h3F});
    chk("clr_digits_noblank", b, {7'h00, 7'h3F, 7'h3F, 7'h3F});
    abort_flag = 1'b0;
    repeat (4) @(negedge clk);

    chk("queue_drained", exp_q.size(), 0);
    chk("commit_count", n_commits, n_pushed);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
